// File: rtl/mc_ctrl_pkg.sv
// Shared codes for the multi-cycle MIPS controller: state encodings, opcode/funct
// values and the select codes used by the IFU, NPC and datapath.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_WB_R     = 4'd7;
    localparam logic [3:0] ST_WB_I     = 4'd8;
    localparam logic [3:0] ST_WB_LW    = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct to instruction-class decoder for mc_ctrl.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       r_arith,
    output logic       imm_logic,
    output logic       load,
    output logic       store,
    output logic       branch,
    output logic       jump,
    output logic       jal,
    output logic       jr,
    output logic       illegal
);

    always_comb begin
        r_arith   = 1'b0;
        imm_logic = 1'b0;
        load      = 1'b0;
        store     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        jal       = 1'b0;
        jr        = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: r_arith = 1'b1;
                    FN_JR:            jr      = 1'b1;
                    default:          illegal = 1'b1;
                endcase
            end
            OP_ORI, OP_LUI: imm_logic = 1'b1;
            OP_LW:          load      = 1'b1;
            OP_SW:          store     = 1'b1;
            OP_BEQ:         branch    = 1'b1;
            OP_J:           jump      = 1'b1;
            OP_JAL:         jal       = 1'b1;
            default:        illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath; PC is written once per instruction.
// Define MC_CTRL_MEM_WAIT_EN to stall MEM_RD/MEM_WR on mem_ready.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] npc_sel,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       mem_we,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic c_r_arith, c_imm, c_load, c_store, c_branch, c_jump, c_jal, c_jr, c_illegal;
    logic is_subu;
    logic is_lui;
    logic mem_done;

    mc_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .r_arith   (c_r_arith),
        .imm_logic (c_imm),
        .load      (c_load),
        .store     (c_store),
        .branch    (c_branch),
        .jump      (c_jump),
        .jal       (c_jal),
        .jr        (c_jr),
        .illegal   (c_illegal)
    );

    assign is_subu = (funct == FN_SUBU);
    assign is_lui  = (opcode == OP_LUI);

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (c_r_arith)                   state_d = ST_EXEC_R;
                else if (c_imm)                  state_d = ST_EXEC_I;
                else if (c_load || c_store)      state_d = ST_MEM_ADDR;
                else if (c_branch)               state_d = ST_BRANCH;
                else if (c_jump || c_jal || c_jr) state_d = ST_JUMP;
                else                             state_d = ST_FETCH;
            end
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_MEM_ADDR: state_d = c_load ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = mem_done ? ST_WB_LW : ST_MEM_RD;
            ST_MEM_WR:   state_d = mem_done ? ST_FETCH : ST_MEM_WR;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Outputs are forced idle while reset is high so no write strobe leaks during reset.
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        npc_sel = NPC_PC4;
        reg_we  = 1'b0;
        reg_dst = RD_RT;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        ext_op  = EXT_ZERO;
        mem_we  = 1'b0;
        wb_sel  = WB_ALU;
        illegal = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: ir_we = 1'b1;
                ST_DECODE: begin
                    if (c_illegal) begin
                        illegal = 1'b1;
                        pc_we   = 1'b1;
                    end
                end
                ST_EXEC_R: alu_op = is_subu ? ALU_SUB : ALU_ADD;
                ST_EXEC_I, ST_WB_I: begin
                    alu_src = 1'b1;
                    ext_op  = is_lui ? EXT_LUI : EXT_ZERO;
                    alu_op  = is_lui ? ALU_PASSB : ALU_OR;
                    if (state_q == ST_WB_I) begin
                        reg_we = 1'b1;
                        pc_we  = 1'b1;
                    end
                end
                ST_MEM_ADDR: begin
                    alu_src = 1'b1;
                    ext_op  = EXT_SIGN;
                end
                ST_MEM_WR: begin
                    mem_we = 1'b1;
                    pc_we  = mem_done;
                end
                ST_WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = RD_RD;
                    pc_we   = 1'b1;
                end
                ST_WB_LW: begin
                    reg_we = 1'b1;
                    wb_sel = WB_MEM;
                    pc_we  = 1'b1;
                end
                ST_BRANCH: begin
                    alu_op  = ALU_SUB;
                    pc_we   = 1'b1;
                    npc_sel = zero ? NPC_BR : NPC_PC4;
                end
                ST_JUMP: begin
                    pc_we   = 1'b1;
                    npc_sel = c_jr ? NPC_JR : NPC_JMP;
                    if (c_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = RD_RA;
                        wb_sel  = WB_PC4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign retire = pc_we;
    assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction reference model queues the expected
// cycle-by-cycle state and controls; a negedge monitor pops and compares them.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_we, pc_we, reg_we, alu_src, mem_we, illegal, retire;
    logic [1:0] npc_sel, reg_dst, ext_op, wb_sel;
    logic [2:0] alu_op;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
        .reg_we(reg_we), .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
        .ext_op(ext_op), .mem_we(mem_we), .wb_sel(wb_sel), .illegal(illegal),
        .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WAITS = 1'b1;
`else
    localparam bit WAITS = 1'b0;
`endif

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_XR = 4'd2, S_XI = 4'd3,
                           S_MA = 4'd4, S_MR = 4'd5, S_MW = 4'd6, S_WR = 4'd7,
                           S_WI = 4'd8, S_WL = 4'd9, S_BR = 4'd10, S_JP = 4'd11;

    // instruction kinds used by the model
    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                   K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] o;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  drv_e[$];
    bit    drv_z[$];
    bit    drv_r[$];
    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    exp_t  mon_e;
    string mon_n;

    logic [17:0] dut_o;
    assign dut_o = {ir_we, pc_we, npc_sel, reg_we, reg_dst, alu_src, alu_op, ext_op,
                    mem_we, wb_sel, illegal, retire};

    function automatic logic [17:0] outs(input logic ir, input logic pc, input logic [1:0] npc,
                                         input logic rwe, input logic [1:0] rdst, input logic asrc,
                                         input logic [2:0] aop, input logic [1:0] eop,
                                         input logic mwe, input logic [1:0] wb, input logic ill);
        return {ir, pc, npc, rwe, rdst, asrc, aop, eop, mwe, wb, ill, pc};
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b100001) return K_ADDU;
                if (fn == 6'b100011) return K_SUBU;
                if (fn == 6'b001000) return K_JR;
                return K_ILL;
            end
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    task automatic add(input logic [3:0] st, input logic [17:0] o, input bit z, input bit r);
        drv_e.push_back({st, o});
        drv_z.push_back(z);
        drv_r.push_back(r);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, want);
        end
    endtask

    // Builds the expected cycles of one instruction, queues them, then drives it.
    // Called at posedge+1 of the cycle in which the DUT sits in FETCH.
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input bit z, input int w, input int lim);
        int  k;
        int  ww;
        logic [2:0] aop;
        logic [1:0] ext;
        k  = kind_of(op, fn);
        ww = WAITS ? w : 0;
        add(S_F, outs(1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 0, 2'b00, 0), rb(), rb());
        if (k == K_ILL) begin
            add(S_D, outs(0, 1, 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 0, 2'b00, 1), rb(), rb());
        end else begin
            add(S_D, 18'd0, rb(), rb());
            case (k)
                K_ADDU, K_SUBU: begin
                    add(S_XR, outs(0, 0, 2'b00, 0, 2'b00, 0, (k == K_SUBU) ? 3'b001 : 3'b000,
                                   2'b00, 0, 2'b00, 0), rb(), rb());
                    add(S_WR, outs(0, 1, 2'b00, 1, 2'b01, 0, 3'b000, 2'b00, 0, 2'b00, 0), rb(), rb());
                end
                K_ORI, K_LUI: begin
                    aop = (k == K_LUI) ? 3'b011 : 3'b010;
                    ext = (k == K_LUI) ? 2'b10 : 2'b00;
                    add(S_XI, outs(0, 0, 2'b00, 0, 2'b00, 1, aop, ext, 0, 2'b00, 0), rb(), rb());
                    add(S_WI, outs(0, 1, 2'b00, 1, 2'b00, 1, aop, ext, 0, 2'b00, 0), rb(), rb());
                end
                K_LW, K_SW: begin
                    add(S_MA, outs(0, 0, 2'b00, 0, 2'b00, 1, 3'b000, 2'b01, 0, 2'b00, 0), rb(), rb());
                    for (int i = 0; i <= ww; i++) begin
                        if (k == K_LW)
                            add(S_MR, 18'd0, rb(), WAITS ? (i == ww) : rb());
                        else
                            add(S_MW, outs(0, (i == ww), 2'b00, 0, 2'b00, 0, 3'b000, 2'b00, 1, 2'b00, 0),
                                rb(), WAITS ? (i == ww) : rb());
                    end
                    if (k == K_LW)
                        add(S_WL, outs(0, 1, 2'b00, 1, 2'b00, 0, 3'b000, 2'b00, 0, 2'b01, 0), rb(), rb());
                end
                K_BEQ:
                    add(S_BR, outs(0, 1, z ? 2'b01 : 2'b00, 0, 2'b00, 0, 3'b001, 2'b00, 0, 2'b00, 0), z, rb());
                K_J:
                    add(S_JP, outs(0, 1, 2'b10, 0, 2'b00, 0, 3'b000, 2'b00, 0, 2'b00, 0), rb(), rb());
                K_JAL:
                    add(S_JP, outs(0, 1, 2'b10, 1, 2'b10, 0, 3'b000, 2'b00, 0, 2'b10, 0), rb(), rb());
                default:
                    add(S_JP, outs(0, 1, 2'b11, 0, 2'b00, 0, 3'b000, 2'b00, 0, 2'b00, 0), rb(), rb());
            endcase
        end
        for (int c = 0; c < drv_e.size() && c < lim; c++) begin
            exp_q.push_back(drv_e[c]);
            tag_q.push_back($sformatf("%s.c%0d", nm, c));
        end
        for (int c = 0; c < drv_e.size() && c < lim; c++) begin
            opcode    = (c == 0) ? 6'($urandom) : op;
            funct     = (c == 0) ? 6'($urandom) : fn;
            zero      = drv_z[c];
            mem_ready = drv_r[c];
            @(posedge clk);
            #1;
        end
        drv_e.delete();
        drv_z.delete();
        drv_r.delete();
    endtask

    // Releases reset at posedge+1 so the next run_instr starts in the FETCH cycle.
    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_reset_state", 32'(state), 32'(S_F));
        check("post_reset_ir_we", 32'(ir_we), 32'd1);
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty state %0d", state);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = tag_q.pop_front();
                checks++;
                if (state !== mon_e.st) begin
                    errors++;
                    $display("FAIL %s state got %0d expected %0d", mon_n, state, mon_e.st);
                end
                checks++;
                if (dut_o !== mon_e.o) begin
                    errors++;
                    $display("FAIL %s outputs got %b expected %b", mon_n, dut_o, mon_e.o);
                end
            end
        end
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         kk;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'(S_F));
        check("reset_outputs", 32'(dut_o), 32'd0);
        release_reset();

        run_instr("addu", 6'b000000, 6'b100001, 1'b0, 0, 99);
        run_instr("subu", 6'b000000, 6'b100011, 1'b0, 0, 99);
        run_instr("beq_z1", 6'b000100, 6'd0, 1'b1, 0, 99);
        run_instr("beq_z0", 6'b000100, 6'd0, 1'b0, 0, 99);
        run_instr("jal", 6'b000011, 6'd0, 1'b0, 0, 99);
        run_instr("jr", 6'b000000, 6'b001000, 1'b0, 0, 99);
        run_instr("j", 6'b000010, 6'd0, 1'b0, 0, 99);
        run_instr("ori", 6'b001101, 6'd0, 1'b0, 0, 99);
        run_instr("lui", 6'b001111, 6'd0, 1'b0, 0, 99);
        run_instr("lw_w3", 6'b100011, 6'd0, 1'b0, 3, 99);
        run_instr("sw_w2", 6'b101011, 6'd0, 1'b0, 2, 99);
        run_instr("ill_3f", 6'b111111, 6'd0, 1'b0, 0, 99);

        // Abort an lw in MEM_ADDR with reset.
        run_instr("lw_abort", 6'b100011, 6'd0, 1'b0, 0, 2);
        chk_en = 1'b0;
        check("pre_abort_state", 32'(state), 32'(S_MA));
        reset = 1'b1;
        #1;
        check("abort_state", 32'(state), 32'(S_F));
        check("abort_outputs", 32'(dut_o), 32'd0);
        @(negedge clk);
        check("abort_hold_outputs", 32'(dut_o), 32'd0);
        release_reset();

        for (int n = 0; n < 80; n++) begin
            kk = $urandom_range(0, 10);
            fn = 6'($urandom);
            case (kk)
                0: begin op = 6'b000000; fn = 6'b100001; end
                1: begin op = 6'b000000; fn = 6'b100011; end
                2: begin op = 6'b000000; fn = 6'b001000; end
                3: op = 6'b001101;
                4: op = 6'b001111;
                5: op = 6'b100011;
                6: op = 6'b101011;
                7: op = 6'b000100;
                8: op = 6'b000010;
                9: op = 6'b000011;
                default: begin
                    if (rb()) begin
                        op = 6'b000000;
                        if (kind_of(op, fn) != K_ILL) fn = 6'b000000;
                    end else begin
                        op = 6'($urandom);
                        if (kind_of(op, fn) != K_ILL) op = 6'b111111;
                    end
                end
            endcase
            run_instr($sformatf("rnd%0d", n), op, fn, rb(), $urandom_range(0, 3), 99);
        end

        chk_en = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
